// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//
// Shared definitions for the round-robin arbiter slice.
//
// Contents:
//   arb_state_t      - arbiter FSM state (IDLE=0, GRANT=1, GAP=2)
//   MAX_HOLD_DEFAULT - default tenure limit in grant cycles
//   HOLD_W           - width of the per-tenure hold counter
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int MAX_HOLD_DEFAULT = 16;

    // Wide enough for the largest legal MAX_HOLD (255).
    // The count stops at MAX_HOLD-1, so it never wraps.
    localparam int HOLD_W = 8;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Purely combinational rotate-and-pick stage of the round-robin arbiter.
// Scans the request vector from index ptr upward and wraps from NUM_REQ-1
// back to 0. It reports the first set bit it finds.
//
// Parameters:
//   NUM_REQ   - number of requesters (2..8)
//   ID_W      - width of an requester index
//
// Ports:
//   req       in   NUM_REQ  request vector
//   ptr       in   ID_W     index where the scan starts (highest priority)
//   winner    out  NUM_REQ  one-hot winner, zero when nothing is requested
//   winner_id out  ID_W     index of the winner, zero when nothing found
//   found     out  1        high when any request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [ID_W-1:0]    winner_id,
    output logic               found
);

    // ptr is always below NUM_REQ and the offset is below NUM_REQ.
    // A single conditional subtraction therefore gives the modulo.
    // This also holds for a requester count that is not a power of two.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;

        winner    = '0;
        winner_id = '0;
        found     = 1'b0;
        cand      = 0;
        cand_id   = '0;

        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_id = ID_W'(cand);
            if (!found && req[cand_id]) begin
                found           = 1'b1;
                winner[cand_id] = 1'b1;
                winner_id       = cand_id;
            end
        end
    end

endmodule : rr_pick

// File: rtl/round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
//
// Round-robin arbiter with a bounded tenure. The arbiter picks a new owner
// from IDLE or GAP. That owner keeps the grant while it requests, for at
// most MAX_HOLD cycles. When the tenure ends, the arbiter inserts one
// zero-grant GAP cycle. The rotation pointer then moves past the owner.
//
// Parameters:
//   NUM_REQ  - number of requesters (2..8)
//   MAX_HOLD - maximum consecutive grant cycles per tenure (2..255)
//
// Ports:
//   clock    in   1        rising-edge clock
//   reset    in   1        asynchronous, active-high reset
//   req      in   NUM_REQ  level-held request vector
//   gnt      out  NUM_REQ  registered one-hot-or-zero grant
//   gnt_id   out  ID_W     index of the current owner, 0 when idle
//   busy     out  1        high whenever gnt is nonzero
//   timeout  out  1        one-cycle pulse when MAX_HOLD cuts a tenure
// ---------------------------------------------------------------------------
module round_robin_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = MAX_HOLD_DEFAULT,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_t           state;
    logic [ID_W-1:0]      ptr;
    logic [HOLD_W-1:0]    hold_cnt;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_found;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .winner    (pick_gnt),
        .winner_id (pick_id),
        .found     (pick_found)
    );

    // gnt_id keeps the current owner during GRANT.
    // So req[gnt_id] is the live request of the owner.
    // timeout is loaded from that bit when a tenure ends:
    //   - the owner dropped its request: no pulse;
    //   - the hold limit cut the tenure: one pulse.
    // The pointer only moves when the arbiter leaves GRANT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pick_found) begin
                        state    <= GRANT;
                        gnt      <= pick_gnt;
                        gnt_id   <= pick_id;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state    <= IDLE;
                        gnt      <= '0;
                        gnt_id   <= '0;
                        busy     <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[gnt_id] || (hold_cnt == HOLD_LAST)) begin
                        state   <= GAP;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        busy    <= 1'b0;
                        timeout <= req[gnt_id];
                        ptr     <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= '0;
                    gnt_id   <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule : round_robin_arbiter

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, meaning maximum consecutive grant cycles per tenure (2..255).
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  NUM_REQ  request vector; bit i means requester i wants the resource; level-held.
REQ-006 Port: gnt  output  NUM_REQ  registered one-hot-or-zero grant vector.
REQ-007 Port: gnt_id  output  clog2(NUM_REQ)  index of current owner; 0 when gnt is zero.
REQ-008 Port: busy  output  1  high whenever gnt is nonzero.
REQ-009 Port: timeout  output  1  one-cycle pulse when a tenure is cut by MAX_HOLD.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT, GAP.
REQ-011 In IDLE or GAP with req nonzero: select first set bit scanning from ptr upward, wrapping NUM_REQ-1 -> 0; go to GRANT; gnt/gnt_id valid the next cycle (1-cycle latency).
REQ-012 In IDLE or GAP with req zero: go to IDLE; gnt stays zero.
REQ-013 In GRANT: hold_cnt increments each cycle, starting at 0 on the first grant cycle.
REQ-014 In GRANT: if req[owner] = 0, go to GAP, clear gnt next cycle, no timeout pulse.
REQ-015 In GRANT: if req[owner] = 1 and hold_cnt = MAX_HOLD-1, go to GAP, clear gnt next cycle, pulse timeout for exactly that one cycle.
REQ-016 Otherwise GRANT SHALL persist and gnt SHALL not change.
REQ-017 Leaving GRANT, ptr SHALL become (owner+1) mod NUM_REQ; it changes at no other time.
REQ-018 GAP SHALL last exactly one cycle, with gnt zero, so that two grants are never adjacent.
REQ-019 gnt SHALL never have more than one bit set.
REQ-020 Requests arriving or dropping for non-owners during GRANT SHALL not affect the current tenure.
REQ-021 Simultaneous requests SHALL resolve only by the ptr rotation; there is no fixed priority.
REQ-022 hold_cnt SHALL be 8 bits wide, reset to 0 on entry to GRANT, and never wrap.

Reset
REQ-023 On reset assertion, immediately: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0.
REQ-024 Reset mid-tenure SHALL drop the grant asynchronously; after release, arbitration restarts from requester 0.
REQ-025 The first arbitration SHALL occur on the first rising clock edge with reset low.

Structure
REQ-026 State encodings (IDLE=0, GRANT=1, GAP=2) and the MAX_HOLD default SHALL live in shared package arb_pkg.
REQ-027 The combinational rotate-and-pick logic (req, ptr -> one-hot winner, index, found) SHALL be sub-module rr_pick; the FSM, counter and pointer stay in round_robin_arbiter.

Verification
REQ-028 Reset pulse 5->20 ns, req=4'b0000 -> gnt=0, busy=0, timeout=0 throughout.
REQ-029 From IDLE with ptr=0, req=4'b1111 held -> grants 0,1,2,3,0 in order; each lasts 16 cycles with a timeout pulse, separated by one zero-gnt GAP cycle.
REQ-030 req=4'b0100 held 3 cycles then dropped -> gnt=4'b0100 for 3 cycles, then GAP, no timeout, ptr=3.
REQ-031 With ptr=3 and req=4'b1001 -> requester 3 wins, then requester 0 (wrap-around).
REQ-032 Reset asserted during a grant to requester 2 -> gnt=0 in the same cycle; after release with req=4'b0110, requester 1 wins.
REQ-033 Owner 1 drops req on the cycle hold_cnt=MAX_HOLD-1 -> release without timeout pulse; at every cycle, an assertion checks that gnt is one-hot-or-zero.
